inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch front end that drives the program counter into the combinational instruction memory. It captures each returned instruction word together with its PC in a small in-order buffer and hands them to decode over a valid/ready handshake. Execute-stage jump/branch redirects (`jeq`…`jmp`) flush the buffer and reload the PC. Fetching stops once the PC runs past the populated memory depth, and resumes on the next redirect back into range.

## Interface
- `ADDR_W`, default 16: PC / instruction address width (matches `INST_ADDR_LENGTH`).
- `INST_W`, default 16: instruction word width (matches `INST_BUS_LENGTH`).
- `MEM_DEPTH`, default 38: number of valid instruction words. The valid range is 0 … MEM_DEPTH-1.
- `RESET_PC`, default 0: first fetch address after reset.
- `BUF_DEPTH`, default 2: instruction buffer entries. Power of two, ≥ 2.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `pc_o`, out, ADDR_W: fetch address to instruction memory.
- `inst_i`, in, INST_W: instruction word for `pc_o`, valid in the same cycle (memory is combinational).
- `redirect_i`, in, 1: one-cycle pulse from execute requesting a control-flow change.
- `redirect_pc_i`, in, ADDR_W: target PC, sampled when `redirect_i`=1.
- `inst_valid_o`, out, 1: buffer head holds a valid instruction.
- `inst_ready_i`, in, 1: decode accepts the head this cycle.
- `inst_o`, out, INST_W: head instruction word. All zeros (nop) when empty.
- `inst_pc_o`, out, ADDR_W: PC of the head instruction. Zero when empty.
- `fetch_done_o`, out, 1: high while in state END.

## Operation
- **State machine:** two states, RUN and END. Reset state is RUN with fetch PC = RESET_PC.
- **RUN, fetch enable:** `fen = (count < BUF_DEPTH) || (inst_valid_o && inst_ready_i)`.
- **RUN, when `fen`=1:** on the edge, push {`pc_o`, `inst_i`} at the buffer tail, then update fetch PC to `pc_o`+1 (ADDR_W-bit modular add).
  - If `pc_o`+1 ≥ MEM_DEPTH, or the add wraps to 0, the next state is END.
- **RUN, when `fen`=0:** fetch PC holds and no push occurs.
- **END:** no pushes. `pc_o` holds its last value. The buffer keeps draining normally. `fetch_done_o`=1.
- **Pop:** occurs when `inst_valid_o && inst_ready_i`. Pop and push in the same cycle are legal, including when the buffer is full. Count stays unchanged in that case.
- **Redirect:** has priority over everything else.
  - On the edge with `redirect_i`=1: buffer count becomes 0 and all entries are discarded, including the head accepted that cycle. No push occurs.
  - Fetch PC becomes `redirect_pc_i`.
  - Next state is RUN if `redirect_pc_i` < MEM_DEPTH, otherwise END.
- **Reset:** asynchronous. Asserting `rst_n` mid-operation immediately clears the buffer and returns to RUN at RESET_PC.
- **Ordering:** the buffer is in-order. `inst_pc_o` always equals the address the word was fetched from.

## Timing
- **Reset values:**
  - `pc_o` = RESET_PC
  - `inst_valid_o` = 0
  - `inst_o` = 0
  - `inst_pc_o` = 0
  - `fetch_done_o` = 0 (or 1 if RESET_PC ≥ MEM_DEPTH)
- **Fetch-to-valid latency:** 1 cycle. The word presented at `pc_o` in cycle N appears at the head in cycle N+1 if the buffer was empty.
- **Throughput:** one instruction per cycle sustained while decode holds `inst_ready_i`=1.
- **Redirect latency:** redirect asserted in cycle N gives `pc_o` = target in cycle N+1, and the target instruction is valid in cycle N+2. `inst_valid_o`=0 in cycle N+1.
- **Stall:** with `inst_ready_i`=0 and the buffer full, `pc_o` is stable until a pop occurs.
- **Outputs:** all outputs are registered or decoded from registers. There is no combinational path from `inst_ready_i` or `redirect_i` to any output.

## Test plan
- **Reset and stream:** memory[0]=16'h8800, memory[1]=16'h8901, `inst_ready_i`=1. Release reset → `pc_o` 0,1,2…; first valid cycle shows `inst_o`=16'h8800 / `inst_pc_o`=0, next cycle 16'h8901 / 1; no gaps.
- **Backpressure:** `inst_ready_i`=0 for 5 cycles → `inst_valid_o` stays 1 with the PC-0 word held, `pc_o` freezes at 2, count reaches 2. Then drive `inst_ready_i`=1 → PCs 0,1,2,3 delivered in order, none dropped or duplicated.
- **Redirect:** redirect to 24 while the buffer holds PCs 22 and 23 → both are flushed, `inst_valid_o`=0 for one cycle, then `inst_pc_o`=24. Also assert `redirect_i` while the head is being accepted → head is discarded and the target still follows.
- **End of memory:** stream to PC 37 → last delivered `inst_pc_o`=37, `fetch_done_o`=1, no further pushes. Then redirect to 33 → fetching restarts at 33 and `fetch_done_o` returns to 0. Redirect to 40 → END immediately, no delivery.
- **Mid-run reset:** assert `rst_n`=0 asynchronously between edges with a full buffer → `inst_valid_o` drops immediately and `pc_o`=RESET_PC. After release, streaming restarts at 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: drives the PC into a combinational instruction
// memory and queues {pc, word} pairs in an in-order buffer for decode.
module inst_fetch_unit #(
    parameter int ADDR_W    = 16,
    parameter int INST_W    = 16,
    parameter int MEM_DEPTH = 38,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              fetch_done_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  BUF_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
    localparam logic [63:0]       MEM_LIM  = 64'(MEM_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_END = 1'b1
    } state_t;

    localparam state_t RST_STATE = (RESET_PC >= MEM_DEPTH) ? ST_END : ST_RUN;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        in_range = (64'(addr) < MEM_LIM);
    endfunction

    state_t             state_r, state_nxt_s;
    logic [ADDR_W-1:0]  pc_r, pc_nxt_s, pc_inc_s;
    logic [PTR_W-1:0]   head_r, head_nxt_s, tail_r, tail_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic [ADDR_W-1:0]  buf_pc_r   [BUF_DEPTH];
    logic [INST_W-1:0]  buf_inst_r [BUF_DEPTH];
    logic               valid_s, pop_s, fen_s, push_s;

    assign valid_s  = (count_r != {CNT_W{1'b0}});
    assign pop_s    = valid_s && inst_ready_i;
    assign fen_s    = (state_r == ST_RUN) && ((count_r < BUF_FULL) || pop_s);
    assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-state logic; a redirect flushes the buffer and overrides fetch and pop.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        push_s      = 1'b0;
        if (redirect_i) begin
            pc_nxt_s    = redirect_pc_i;
            count_nxt_s = {CNT_W{1'b0}};
            head_nxt_s  = {PTR_W{1'b0}};
            tail_nxt_s  = {PTR_W{1'b0}};
            if (in_range(redirect_pc_i)) begin
                state_nxt_s = ST_RUN;
            end else begin
                state_nxt_s = ST_END;
            end
        end else begin
            push_s = fen_s;
            if (fen_s) begin
                pc_nxt_s   = pc_inc_s;
                tail_nxt_s = tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
                // Running off the populated range, or wrapping the PC, ends fetch.
                if (!in_range(pc_inc_s) || (pc_inc_s == {ADDR_W{1'b0}})) begin
                    state_nxt_s = ST_END;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end else begin
                pc_nxt_s = pc_r;
            end
            if (pop_s) begin
                head_nxt_s = head_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                head_nxt_s = head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // State, PC and buffer pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RST_STATE;
            pc_r    <= RST_PC;
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Buffer storage, written at the tail on each fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc_r[i]   <= {ADDR_W{1'b0}};
                buf_inst_r[i] <= {INST_W{1'b0}};
            end
        end else if (push_s) begin
            buf_pc_r[tail_r]   <= pc_r;
            buf_inst_r[tail_r] <= inst_i;
        end
    end

    assign pc_o         = pc_r;
    assign inst_valid_o = valid_s;
    assign inst_o       = valid_s ? buf_inst_r[head_r] : {INST_W{1'b0}};
    assign inst_pc_o    = valid_s ? buf_pc_r[head_r] : {ADDR_W{1'b0}};
    assign fetch_done_o = (state_r == ST_END);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomised bench for inst_fetch_unit: a queue-based reference model of the
// fetch buffer is compared against the DUT by a negedge monitor.
module tb_inst_fetch_unit;

    localparam int MEM = 38;
    localparam int BUF = 2;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_o;
    logic [15:0] inst_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [15:0] inst_o;
    logic [15:0] inst_pc_o;
    logic        fetch_done_o;

    logic [15:0] mem [0:MEM-1];
    ent_t        exp_q[$];
    logic [15:0] m_pc   = 16'd0;
    logic        m_done = 1'b0;
    int          n_chk  = 0;
    int          n_fail = 0;

    inst_fetch_unit #(
        .ADDR_W(16), .INST_W(16), .MEM_DEPTH(MEM), .RESET_PC(0), .BUF_DEPTH(BUF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .inst_i(inst_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .fetch_done_o(fetch_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        inst_i = 16'h0000;
        if (pc_o < 16'(MEM)) inst_i = mem[pc_o];
        else                 inst_i = 16'h0000;
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        if (a < 16'(MEM)) return mem[a];
        return 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch PC, END flag and the ordered list of buffered words.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_pc   = 16'd0;
                m_done = 1'b0;
            end else if (redirect_i) begin
                exp_q.delete();
                m_pc   = redirect_pc_i;
                m_done = (redirect_pc_i >= 16'(MEM));
            end else begin
                automatic bit pop = (exp_q.size() > 0) && inst_ready_i;
                automatic bit fen = !m_done && ((exp_q.size() < BUF) || pop);
                if (pop) void'(exp_q.pop_front());
                if (fen) begin
                    exp_q.push_back('{pc: m_pc, inst: word_at(m_pc)});
                    m_pc = m_pc + 16'd1;
                    if (m_pc >= 16'(MEM) || m_pc == 16'd0) m_done = 1'b1;
                end
            end
        end
    end

    // Monitor: compare the DUT's visible state with the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("pc_o", 32'(pc_o), 32'(m_pc));
            chk("fetch_done", 32'(fetch_done_o), 32'(m_done));
            chk("inst_valid", 32'(inst_valid_o), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("inst_pc", 32'(inst_pc_o), 32'(exp_q[0].pc));
                chk("inst", 32'(inst_o), 32'(exp_q[0].inst));
            end else begin
                chk("inst_pc_empty", 32'(inst_pc_o), 32'd0);
                chk("inst_empty", 32'(inst_o), 32'd0);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic rd, input logic [15:0] tgt);
        inst_ready_i  = rdy;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        @(posedge clk);
        #1;
        redirect_i    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h8800;
        mem[1] = 16'h8901;
        rst_n = 1'b0;
        inst_ready_i = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = 16'd0;
        #2;
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_done", 32'(fetch_done_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stream from reset, then backpressure from PC 0
        repeat (6) cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 16'd0);
        repeat (5) cyc(1'b0, 1'b0, 16'd0);
        chk("stall_pc", 32'(pc_o), 32'd2);
        chk("stall_head", 32'(inst_o), 32'h8800);
        repeat (6) cyc(1'b1, 1'b0, 16'd0);

        // Redirect over a full buffer, then redirect while the head is accepted
        cyc(1'b0, 1'b1, 16'd22);
        repeat (3) cyc(1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 16'd24);
        chk("flush_valid", 32'(inst_valid_o), 32'd0);
        chk("flush_pc", 32'(pc_o), 32'd24);
        repeat (4) cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd28);
        repeat (4) cyc(1'b1, 1'b0, 16'd0);

        // End of memory, restart inside, redirect out of range
        cyc(1'b1, 1'b1, 16'd30);
        repeat (14) cyc(1'b1, 1'b0, 16'd0);
        chk("end_done", 32'(fetch_done_o), 32'd1);
        cyc(1'b1, 1'b1, 16'd33);
        chk("restart_done", 32'(fetch_done_o), 32'd0);
        repeat (8) cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd40);
        repeat (4) cyc(1'b1, 1'b0, 16'd0);

        // Random traffic
        repeat (400) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                16'($urandom_range(0, 45)));
        end

        // Asynchronous reset with a full buffer
        cyc(1'b0, 1'b1, 16'd5);
        repeat (3) cyc(1'b0, 1'b0, 16'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(inst_valid_o), 32'd0);
        chk("async_pc", 32'(pc_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cyc(1'b1, 1'b0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
